// File: rtl/burst_mem_responder_if.sv
// Burst memory port between the cacheline adaptor (master) and the memory responder (slave).
// A 256-bit line is carried as four 64-bit beats, one per mem_resp cycle.
interface burst_mem_responder_if;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Burst memory responder: serves 256-bit line reads/writes as 4-beat 64-bit bursts
// from an internal line array, with a programmable request-to-first-beat latency.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; latches line index and op
// WAIT  | latency countdown before the first beat
// BURST | mem_resp high, one beat per cycle, beats 0..3
// DONE  | one dead cycle so the initiator can drop its request
module burst_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_mem_responder_if.slave  bus,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  localparam logic [3:0] LAT_RELOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_lat_cnt, w_lat_cnt_nxt;
  logic [1:0]             r_beat, w_beat_nxt;
  logic [ADDR_BITS-1:0]   r_line, w_line_nxt;
  logic                   r_is_read, w_is_read_nxt;
  logic                   w_req;
  logic                   w_unused_addr;

  // Beat-granular storage: index {line, beat}, beat 0 is the line's low 64 bits.
  logic [63:0] r_mem [0:(1 << (ADDR_BITS + 2)) - 1];

  assign w_req         = bus.mem_read | bus.mem_write;
  assign w_unused_addr = ^{bus.mem_addr[31:ADDR_BITS+5], bus.mem_addr[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 4'd0;
      r_beat    <= 2'd0;
      r_line    <= '0;
      r_is_read <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_beat    <= w_beat_nxt;
      r_line    <= w_line_nxt;
      r_is_read <= w_is_read_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_beat_nxt    = r_beat;
    w_line_nxt    = r_line;
    w_is_read_nxt = r_is_read;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_line_nxt    = bus.mem_addr[ADDR_BITS+4:5];
          w_is_read_nxt = bus.mem_read;
          w_beat_nxt    = 2'd0;
          if (LATENCY == 1) begin
            w_state_nxt = S_BURST;
          end else begin
            w_state_nxt   = S_WAIT;
            w_lat_cnt_nxt = LAT_RELOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == 4'd0) begin
          w_state_nxt = S_BURST;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - 4'd1;
        end
      end
      S_BURST: begin
        w_beat_nxt = r_beat + 2'd1;
        if (r_beat == 2'd3) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Write beats commit on the edge closing each response cycle; no reset on the array.
  always_ff @(posedge clk) begin
    if (r_state == S_BURST && !r_is_read) begin
      r_mem[{r_line, r_beat}] <= bus.mem_wdata;
    end
  end

  assign bus.mem_resp  = (r_state == S_BURST);
  assign bus.mem_rdata = (r_state == S_BURST && r_is_read) ? r_mem[{r_line, r_beat}] : 64'd0;
  assign busy          = (r_state != S_IDLE);

endmodule
